// File: rtl/aes_pkg.sv
// aes_pkg: shared FSM state, mux select codes and round count for the AES-128 encryption path
package aes_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_ARK, ST_SB, ST_SR, ST_MC, ST_DONE} aes_state_t;
    localparam logic [1:0] SEL_ARK = 2'b00;
    localparam logic [1:0] SEL_SB  = 2'b01;
    localparam logic [1:0] SEL_MC  = 2'b10;
    localparam logic [1:0] SEL_SR  = 2'b11;
    localparam int AES_NUM_ROUNDS = 10;
endpackage

// File: rtl/encryption_round_counter.sv
// encryption_round_counter: 4-bit round index with clear, increment and terminal flag
module encryption_round_counter
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] round_num,
    output logic       last
);
    // clear wins over increment; the FSM never increments past the final round
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) round_num <= '0;
        else if (clr) round_num <= '0;
        else if (inc) round_num <= round_num + 4'd1;
    end
    assign last = round_num == 4'(NUM_ROUNDS);
endmodule

// File: rtl/encryption_controller.sv
// encryption_controller: sequences AES-128 round steps through the encryption mux and holds the state
module encryption_controller
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] process_out_data,
    output logic [1:0]   process_output,
    output logic [127:0] cur_state_data,
    output logic [3:0]   round_num,
    output logic         busy,
    output logic         done,
    output logic [127:0] ciphertext
);
    aes_state_t state;
    logic last;
    encryption_round_counter #(.NUM_ROUNDS(NUM_ROUNDS)) u_round (
        .clk(clk),
        .n_rst(n_rst),
        .clr(state == ST_IDLE && start),
        .inc(state == ST_ARK && !last),
        .round_num(round_num),
        .last(last)
    );
    // step FSM; outputs are registered together with the next state so they decode from it
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state          <= ST_IDLE;
            cur_state_data <= '0;
            ciphertext     <= '0;
            process_output <= SEL_ARK;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    cur_state_data <= plaintext;
                    state          <= ST_ARK;
                    process_output <= SEL_ARK;
                    busy           <= 1'b1;
                end
                ST_ARK: begin
                    cur_state_data <= process_out_data;
                    if (last) begin
                        ciphertext     <= process_out_data;
                        state          <= ST_DONE;
                        process_output <= SEL_ARK;
                        done           <= 1'b1;
                    end else begin
                        state          <= ST_SB;
                        process_output <= SEL_SB;
                    end
                end
                ST_SB: begin
                    cur_state_data <= process_out_data;
                    state          <= ST_SR;
                    process_output <= SEL_SR;
                end
                ST_SR: begin
                    cur_state_data <= process_out_data;
                    state          <= last ? ST_ARK : ST_MC;
                    process_output <= last ? SEL_ARK : SEL_MC;
                end
                ST_MC: begin
                    cur_state_data <= process_out_data;
                    state          <= ST_ARK;
                    process_output <= SEL_ARK;
                end
                default: begin
                    state          <= ST_IDLE;
                    process_output <= SEL_ARK;
                    busy           <= 1'b0;
                    done           <= 1'b0;
                end
            endcase
        end
    end
endmodule
